// File: rtl/seg_scan_display_if.sv
// Signal bundle between the debug data sources, the scan driver and the board pins.
// The slave side is the scan driver; the master side feeds channel data and controls.
interface seg_scan_display_if #(
  parameter int DIGITS = 8,
  parameter int CH     = 8,
  parameter int CW     = (CH > 1) ? $clog2(CH) : 1
);
  logic [CH*DIGITS*4-1:0] ch_data;
  logic [CW-1:0]          ch_sel;
  logic                   auto_cycle;
  logic                   freeze;
  logic                   blank_lz;
  logic [DIGITS-1:0]      dp_mask;
  logic [DIGITS-1:0]      an;
  logic [6:0]             seg;
  logic                   dp;
  logic [CW-1:0]          chan_shown;
  logic                   frame_tick;

  modport master (
    output ch_data, ch_sel, auto_cycle, freeze, blank_lz, dp_mask,
    input  an, seg, dp, chan_shown, frame_tick
  );

  modport slave (
    input  ch_data, ch_sel, auto_cycle, freeze, blank_lz, dp_mask,
    output an, seg, dp, chan_shown, frame_tick
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver: prescaled digit scan, per-frame snapshot of a
// selected or auto-rotated channel, leading-zero blanking and decimal points.
module seg_scan_display #(
  parameter int DIGITS        = 8,
  parameter int CH            = 8,
  parameter int CLK_DIV       = 50000,
  parameter int FRAMES_PER_CH = 256,
  parameter int CW            = (CH > 1) ? $clog2(CH) : 1
) (
  input logic               clk,
  input logic               rst,
  seg_scan_display_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (FRAMES_PER_CH > 1) ? $clog2(FRAMES_PER_CH) : 1;
  localparam int SW = DIGITS * 4;

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     fcnt;
  logic [CW-1:0]     chan;
  logic [CW-1:0]     chan_next;
  logic [SW-1:0]     snap;
  logic              tick;
  logic              wrap;
  logic              last_frame;
  logic              upper_zero;
  logic [DIGITS-1:0] blank;
  logic [3:0]        nib;

  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'h0: encode = 7'h40;
      4'h1: encode = 7'h79;
      4'h2: encode = 7'h24;
      4'h3: encode = 7'h30;
      4'h4: encode = 7'h19;
      4'h5: encode = 7'h12;
      4'h6: encode = 7'h02;
      4'h7: encode = 7'h78;
      4'h8: encode = 7'h00;
      4'h9: encode = 7'h18;
      4'hA: encode = 7'h08;
      4'hB: encode = 7'h03;
      4'hC: encode = 7'h46;
      4'hD: encode = 7'h21;
      4'hE: encode = 7'h06;
      default: encode = 7'h0E;
    endcase
  endfunction

  assign tick       = (pre == PW'(CLK_DIV - 1));
  assign wrap       = tick && (idx == IW'(DIGITS - 1));
  assign last_frame = (fcnt == FW'(FRAMES_PER_CH - 1));
  assign nib        = snap[int'(idx)*4 +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (tick) begin
      pre <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Out-of-range manual selections fall back to channel 0.
  always_comb begin
    chan_next = chan;
    if (!bus.auto_cycle) begin
      chan_next = (int'(bus.ch_sel) >= CH) ? '0 : bus.ch_sel;
    end else if (last_frame) begin
      chan_next = (int'(chan) == CH - 1) ? '0 : chan + 1'b1;
    end
  end

  // Snapshot only at the frame wrap so a frame never mixes two data words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan <= '0;
      snap <= '0;
      fcnt <= '0;
    end else begin
      if (wrap && !bus.freeze) begin
        chan <= chan_next;
        snap <= bus.ch_data[int'(chan_next)*SW +: SW];
      end
      if (!bus.auto_cycle) begin
        fcnt <= '0;
      end else if (wrap && !bus.freeze) begin
        fcnt <= last_frame ? '0 : fcnt + 1'b1;
      end
    end
  end

  // Scan from the top digit down; a digit blanks while everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (snap[i*4 +: 4] == 4'h0);
      blank[i]   = bus.blank_lz && upper_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an         <= '1;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.chan_shown <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= ~(DIGITS'(1) << idx);
      bus.seg        <= blank[idx] ? 7'h7F : encode(nib);
      bus.dp         <= ~bus.dp_mask[idx];
      bus.chan_shown <= chan;
      bus.frame_tick <= (pre == '0) && (idx == '0);
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display: a frame-level model predicts each displayed
// frame into a queue; a monitor pops one per frame_tick and checks every cycle of it.
module tb_seg_scan_display;
  localparam int DIGITS   = 4;
  localparam int CH       = 3;
  localparam int CLK_DIV  = 4;
  localparam int FPC      = 2;
  localparam int FRAME    = DIGITS * CLK_DIV;
  localparam int N_FRAMES = 48;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int          chan;
    logic [15:0] word;
    logic        blank;
    logic [3:0]  dpm;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst;
  int     n_checks = 0;
  int     n_errors = 0;
  int     frames_checked = 0;
  bit     done = 1'b0;
  bit     mon_exit = 1'b0;
  frame_t exp_q[$];

  logic [15:0] cur_data [CH];
  int          cur_sel;
  bit          cur_auto;
  bit          cur_freeze;
  bit          next_blank;
  logic [3:0]  next_dp;
  int          m_chan;
  int          m_fcnt;
  logic [15:0] m_word;

  seg_scan_display_if #(.DIGITS(DIGITS), .CH(CH)) bus ();

  seg_scan_display #(
    .DIGITS(DIGITS), .CH(CH), .CLK_DIV(CLK_DIV), .FRAMES_PER_CH(FPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {1'b0, bus.an, bus.seg, bus.dp, bus.chan_shown, bus.frame_tick};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 1) w[i*4 +: 4] = 4'($urandom_range(1, 15));
    return w;
  endfunction

  // Display rules: digit d holds nibble d for CLK_DIV cycles; zero digits above the
  // first nonzero one go dark when blanking is on, digit 0 never does.
  function automatic logic [15:0] expect_cycle(input frame_t fr, input int c);
    int          d     = c / CLK_DIV;
    logic [15:0] upper = fr.word >> (4 * d);
    logic [3:0]  n     = upper[3:0];
    logic [6:0]  s     = (fr.blank && d >= 1 && upper == 16'h0) ? 7'h7F : SEG_TAB[n];
    logic [3:0]  a     = ~(4'b0001 << d);
    return {1'b0, a, s, ~fr.dpm[d], 2'(fr.chan), (c == 0)};
  endfunction

  task automatic drive_inputs();
    bus.ch_data    = {cur_data[2], cur_data[1], cur_data[0]};
    bus.ch_sel     = 2'(cur_sel);
    bus.auto_cycle = cur_auto;
    bus.freeze     = cur_freeze;
  endtask

  task automatic model_wrap();
    if (!cur_auto) begin
      m_fcnt = 0;
      if (!cur_freeze) m_chan = (cur_sel < CH) ? cur_sel : 0;
    end else if (!cur_freeze) begin
      if (m_fcnt == FPC - 1) begin
        m_chan = (m_chan + 1) % CH;
        m_fcnt = 0;
      end else begin
        m_fcnt++;
      end
    end
    if (!cur_freeze) m_word = cur_data[m_chan];
  endtask

  // Called at the negedge after edge n; edge n+1 is a frame wrap when n+1 is a multiple of FRAME.
  task automatic apply_stimulus(input int n);
    int ph = n % FRAME;
    frame_t fr;
    if (ph == FRAME - 1) begin
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 1) == 1) cur_data[k] = rand_word();
      cur_sel    = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) cur_auto = !cur_auto;
      cur_freeze = ($urandom_range(0, 3) == 0);
      drive_inputs();
      model_wrap();
      next_blank = ($urandom_range(0, 2) != 0);
      next_dp    = 4'($urandom_range(0, 15));
      if ((n + 1) / FRAME <= N_FRAMES) begin
        fr.chan = m_chan; fr.word = m_word; fr.blank = next_blank; fr.dpm = next_dp;
        exp_q.push_back(fr);
      end
    end else if (ph == 0) begin
      bus.blank_lz = next_blank;
      bus.dp_mask  = next_dp;
    end else if ($urandom_range(0, 2) == 0) begin
      cur_data[$urandom_range(0, CH - 1)] = rand_word();
      cur_sel    = $urandom_range(0, 3);
      cur_freeze = ($urandom_range(0, 1) == 1);
      drive_inputs();
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int t = 0;
    while (bus.an !== target && t < 3 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (bus.an !== target) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timeout, got an=%b expected %b", name, bus.an, target);
    end
  endtask

  initial begin : monitor
    frame_t fr;
    while (!done) begin
      @(negedge clk);
      if (rst === 1'b0 && bus.frame_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_frame at %0t: got frame_tick=1 expected no frame", $time);
        end else begin
          fr = exp_q.pop_front();
          frames_checked++;
          for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            check_output($sformatf("frame%0d_cyc%0d", frames_checked - 1, c), outs(), expect_cycle(fr, c));
          end
        end
      end
    end
    mon_exit = 1'b1;
  end

  initial begin : stimulus
    frame_t fr0;
    int t;
    rst = 1'b1;
    for (int k = 0; k < CH; k++) cur_data[k] = rand_word();
    cur_sel    = $urandom_range(0, 3);
    cur_auto   = 1'b1;
    cur_freeze = 1'b0;
    drive_inputs();
    next_blank   = 1'b1;
    next_dp      = 4'($urandom_range(0, 15));
    bus.blank_lz = next_blank;
    bus.dp_mask  = next_dp;
    repeat (2) @(negedge clk);
    check_output("reset_state", outs(), {1'b0, 4'hF, 7'h7F, 1'b1, 2'b00, 1'b0});

    m_chan = 0; m_fcnt = 0; m_word = '0;
    fr0.chan = 0; fr0.word = '0; fr0.blank = next_blank; fr0.dpm = next_dp;
    exp_q.push_back(fr0);
    rst = 1'b0;
    for (int n = 1; n <= FRAME * (N_FRAMES + 1); n++) begin
      @(negedge clk);
      apply_stimulus(n);
      if (n == FRAME * N_FRAMES + FRAME / 2) done = 1'b1;
    end

    t = 0;
    while (!mon_exit && t < 4 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (!mon_exit) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL monitor_exit: timeout, got running expected idle");
    end
    check_output("frames_seen", 16'(frames_checked), 16'(N_FRAMES + 1));
    check_output("queue_drained", 16'(exp_q.size()), 16'd0);

    // Decimal point follows the live mask, then reset lands between edges.
    bus.freeze   = 1'b0;
    bus.blank_lz = 1'b0;
    bus.dp_mask  = 4'b0100;
    @(negedge clk);
    wait_an(4'b1101, "wait_digit1");
    check_output("dp_digit1_off", {15'b0, bus.dp}, 16'd1);
    wait_an(4'b1011, "wait_digit2");
    check_output("dp_digit2_on", {15'b0, bus.dp}, 16'd0);
    #2 rst = 1'b1;
    #1 check_output("async_reset", outs(), {1'b0, 4'hF, 7'h7F, 1'b1, 2'b00, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("first_edge_after_reset", outs(), {1'b0, 4'b1110, 7'h40, 1'b1, 2'b00, 1'b1});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
